// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_if : byte push handshake into the UART transmit FIFO
// Revision 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : buffered 8N1 UART transmitter, LSB first, back-to-back frames
// Revision 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int FIFO_AW   = 3
) (
   input  wire logic         clk_50M,
   input  wire logic         rst_n,
   uart_tx_fifo_if.slave     tx_if,
   output logic              rs232_tx,
   output logic              tx_busy,
   output logic [FIFO_AW:0]  fifo_level,
   output logic              overflow
);

   localparam int DEPTH        = 1 << FIFO_AW;
   localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE - 1;
   localparam int BAUD_W       = (BAUD_CNT_MAX > 0) ? $clog2(BAUD_CNT_MAX + 1) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_CNT_MAX);
   localparam logic [FIFO_AW:0]  LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic [FIFO_AW:0]    level_q;
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [7:0]          mem_q [DEPTH];
   logic                full, push, pop;

   // Full is judged on the registered level, so a same-cycle pop never frees a slot
   assign full           = (level_q == LEVEL_FULL);
   assign tx_if.tx_ready = ~full;
   assign push           = tx_if.tx_valid & ~full;
   assign overflow       = tx_if.tx_valid & full;
   assign fifo_level     = level_q;
   assign rs232_tx       = tx_q;
   assign tx_busy        = (state_q != IDLE) | (level_q != '0);

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk_50M) begin
      if (push) mem_q[wr_ptr_q] <= tx_if.tx_data;
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d carries the line level of the state being entered, keeping the output a pure flop
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (level_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (level_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : randomized scoreboard bench with a line-decoding monitor
// Revision 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 3_125_000;
   localparam int AW       = 3;
   localparam int DEPTH    = 1 << AW;
   localparam int B        = CLK_FREQ / BAUD;   // clocks per bit

   typedef struct {
      logic [7:0] d;
      int         t;
   } frame_t;

   logic          clk_50M = 1'b0;
   logic          rst_n   = 1'b0;
   logic          rs232_tx, tx_busy, overflow;
   logic [AW:0]   fifo_level;

   uart_tx_fifo_if tx_if ();

   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_AW(AW)) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .tx_if      (tx_if),
      .rs232_tx   (rs232_tx),
      .tx_busy    (tx_busy),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk_50M = ~clk_50M;

   // Reference model: FIFO contents, earliest edge the transmitter may take the next byte
   logic [7:0] mq [$];
   frame_t     exp_q [$];
   int         cyc         = 0;
   int         next_pop_ok = 0;
   int         checks      = 0;
   int         errors      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] d);
      bit full_before;
      cyc++;
      if (!rst_n) return;
      full_before = (mq.size() == DEPTH);
      if (mq.size() > 0 && cyc >= next_pop_ok) begin
         frame_t f;
         f.d = mq.pop_front();
         f.t = cyc;
         exp_q.push_back(f);
         next_pop_ok = cyc + 10 * B;
      end
      if (v && !full_before) mq.push_back(d);
   endtask

   task automatic tick(input bit v, input logic [7:0] d);
      tx_if.tx_valid = v;
      tx_if.tx_data  = d;
      #1;
      chk("overflow", {31'd0, overflow}, {31'd0, (v && rst_n && mq.size() == DEPTH)});
      @(posedge clk_50M);
      model_step(v, d);
      @(negedge clk_50M);
      tx_if.tx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
   endtask

   // Monitor: a UART receiver sampling mid-bit, compared against the popped-byte scoreboard
   bit         mon_active = 1'b0;
   bit         mon_has_exp;
   int         mon_cnt;
   frame_t     mon_exp;
   logic [7:0] mon_byte;

   always @(negedge clk_50M) begin
      if (!rst_n) begin
         chk("reset_line", {31'd0, rs232_tx}, 32'd1);
         chk("reset_level", {28'd0, fifo_level}, 32'd0);
         chk("reset_busy", {31'd0, tx_busy}, 32'd0);
         chk("reset_ready", {31'd0, tx_if.tx_ready}, 32'd1);
         mon_active = 1'b0;
      end else begin
         chk("level", {28'd0, fifo_level}, mq.size());
         chk("busy", {31'd0, tx_busy}, {31'd0, (mq.size() != 0 || cyc < next_pop_ok)});
         chk("ready", {31'd0, tx_if.tx_ready}, {31'd0, (mq.size() < DEPTH)});
         if (!mon_active) begin
            if (rs232_tx === 1'b0) begin
               mon_active  = 1'b1;
               mon_cnt     = 0;
               mon_has_exp = (exp_q.size() != 0);
               if (mon_has_exp) begin
                  mon_exp = exp_q.pop_front();
                  chk("start_cycle", cyc, mon_exp.t);
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", cyc);
               end
            end
         end else begin
            mon_cnt++;
            if (mon_cnt % B == B / 2) begin
               int k;
               k = mon_cnt / B;
               if (k == 0) begin
                  chk("start_bit", {31'd0, rs232_tx}, 32'd0);
               end else if (k <= 8) begin
                  mon_byte[k-1] = rs232_tx;
               end else begin
                  chk("stop_bit", {31'd0, rs232_tx}, 32'd1);
                  if (mon_has_exp) chk("data_byte", {24'd0, mon_byte}, {24'd0, mon_exp.d});
                  mon_active = 1'b0;
               end
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((mq.size() != 0 || cyc < next_pop_ok || mon_active) && n < 20000) begin
         tick(1'b0, 8'h00);
         n++;
      end
      chk("drain_timeout", {31'd0, (n >= 20000)}, 32'd0);
      idle(3);
   endtask

   initial begin
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;
      @(negedge clk_50M);
      idle(4);
      rst_n = 1'b1;
      idle(2);

      // single byte from idle
      tick(1'b1, 8'h55);
      drain();

      // three consecutive pushes, back-to-back frames
      tick(1'b1, 8'h01);
      tick(1'b1, 8'h02);
      tick(1'b1, 8'h03);
      drain();

      // fill past capacity: nine accepted, then 0xFF dropped with overflow
      for (int i = 0; i < 9; i++) tick(1'b1, 8'hA0 + 8'(i));
      tick(1'b1, 8'hFF);
      tick(1'b1, 8'hFE);
      drain();

      // random stream holding the FIFO near full, exercises pointer wrap
      for (int i = 0; i < 4000; i++) begin
         tick(($urandom_range(0, 7) == 0), 8'($urandom));
      end
      drain();

      // reset in the middle of a data bit with four bytes queued
      for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
      idle(3 * B);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_line", {31'd0, rs232_tx}, 32'd1);
      chk("midreset_level", {28'd0, fifo_level}, 32'd0);
      mq.delete();
      exp_q.delete();
      next_pop_ok = 0;
      idle(3);
      rst_n = 1'b1;
      idle(30 * B);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
